// File: rtl/shift_reg.sv
// ---------------------------------------------------------------------------
// shift_reg
//
// Parallel-load, right-shift register. While en is low the register follows
// the parallel load value on every clock. While en is high it shifts right by
// one position per clock, with the vacated MSB filled according to FILL_MODE.
//
// Parameters:
//   WIDTH     register width in bits (must be >= 2)
//   FILL_MODE fill for the vacated MSB on a shift:
//               0 = logical    (fill 0)
//               1 = arithmetic (replicate old MSB)
//               2 = rotate     (old LSB enters MSB)
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-low reset
//   en    in   1      1 = shift right, 0 = parallel load
//   load  in   WIDTH  parallel load value
//   shr   out  WIDTH  current register contents
//   sout  out  1      bit shifted out on the most recent shift (registered)
//   zero  out  1      combinational, 1 when shr == 0
// ---------------------------------------------------------------------------
module shift_reg #(
    parameter int WIDTH     = 4,
    parameter int FILL_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] shr,
    output logic             sout,
    output logic             zero
);

    // Bit that enters the MSB position on a shift. An out-of-range FILL_MODE
    // falls back to logical fill so the register never picks up an X.
    function automatic logic fill_bit(input logic [WIDTH-1:0] cur);
        case (FILL_MODE)
            1:       fill_bit = cur[WIDTH-1];
            2:       fill_bit = cur[0];
            default: fill_bit = 1'b0;
        endcase
    endfunction

    // Reset clears immediately; after release the first rising edge with rst
    // high performs the first load or shift. sout only changes on a shift so
    // it keeps reporting the last bit shifted out across parallel loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shr  <= '0;
            sout <= 1'b0;
        end else if (en) begin
            shr  <= {fill_bit(shr), shr[WIDTH-1:1]};
            sout <= shr[0];
        end else begin
            shr  <= load;
        end
    end

    assign zero = (shr == '0);

endmodule

// File: tb/tb_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_shift_reg
//
// Bench for shift_reg. Three instances (logical, arithmetic, rotate fill)
// share clock, reset and inputs. A reference model holds each register value
// as an integer and applies the shift rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_shift_reg;

    localparam int W = 4;
    localparam int MSB_VAL = 1 << (W - 1);
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] load;

    logic [W-1:0] shr_o  [3];
    logic         sout_o [3];
    logic         zero_o [3];

    int n_tests;
    int n_fail;

    // Reference state per fill mode
    int m_val [3];
    int m_out [3];

    shift_reg #(.WIDTH(W), .FILL_MODE(0)) u_log (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .shr(shr_o[0]), .sout(sout_o[0]), .zero(zero_o[0])
    );

    shift_reg #(.WIDTH(W), .FILL_MODE(1)) u_ari (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .shr(shr_o[1]), .sout(sout_o[1]), .zero(zero_o[1])
    );

    shift_reg #(.WIDTH(W), .FILL_MODE(2)) u_rot (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .shr(shr_o[2]), .sout(sout_o[2]), .zero(zero_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0;
            m_out[i] = 0;
        end
    endtask

    task automatic model_edge(input logic e, input int l);
        for (int i = 0; i < 3; i++) begin
            if (e) begin
                int v;
                v = m_val[i];
                m_out[i] = v % 2;
                case (i)
                    0: m_val[i] = v / 2;
                    1: m_val[i] = v / 2 + (v & MSB_VAL);
                    default: m_val[i] = v / 2 + (v % 2) * MSB_VAL;
                endcase
            end else begin
                m_val[i] = l & MASK;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s shr m%0d", tag, i), int'(shr_o[i]), m_val[i]);
            check($sformatf("%s sout m%0d", tag, i), int'(sout_o[i]), m_out[i]);
            check($sformatf("%s zero m%0d", tag, i), int'(zero_o[i]), (m_val[i] == 0) ? 1 : 0);
        end
    endtask

    // Called right after a falling edge: drive inputs, take one rising edge,
    // check shortly after it, then return aligned to the next falling edge.
    task automatic step(input logic e, input int l, input string tag);
        en   = e;
        load = l[W-1:0];
        @(posedge clk);
        if (rst) model_edge(e, l);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Async reset between edges: outputs must clear before any clock edge,
    // stay clear across an edge, then release at a falling edge.
    task automatic async_reset_pulse(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all({tag, " async"});
        @(posedge clk);
        #1;
        check_all({tag, " held"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b0;
        en   = 1'b0;
        load = 4'b0111;
        model_reset();

        // 1. Reset and first load
        #3;
        check_all("reset");
        check("reset zero", int'(zero_o[0]), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 4'b0111, "load0111");
        check("load shr", int'(shr_o[0]), 7);
        check("load zero", int'(zero_o[0]), 0);

        // 2. Logical shifts from 0111 down to zero
        step(1'b1, 4'b0000, "lsh1");
        check("lsh1 shr", int'(shr_o[0]), 3);
        step(1'b1, 4'b1111, "lsh2");
        check("lsh2 shr", int'(shr_o[0]), 1);
        step(1'b1, 4'b0101, "lsh3");
        check("lsh3 shr", int'(shr_o[0]), 0);
        check("lsh3 zero", int'(zero_o[0]), 1);
        check("lsh3 sout", int'(sout_o[0]), 1);
        step(1'b1, 4'b1010, "lsh4");
        check("lsh4 sout", int'(sout_o[0]), 0);

        // 3. Shift once then drop en; sout must hold across the load
        step(1'b0, 4'b0111, "reload");
        step(1'b1, 4'b0000, "sh1");
        check("sh1 shr", int'(shr_o[0]), 3);
        step(1'b0, 4'b1010, "hold_load");
        check("hold_load shr", int'(shr_o[0]), 10);
        check("hold_load sout", int'(sout_o[0]), 1);

        // 4. Arithmetic fill from 1000
        step(1'b0, 4'b1000, "ld1000");
        step(1'b1, 4'b0000, "ash1");
        check("ash1 shr", int'(shr_o[1]), 12);
        step(1'b1, 4'b0000, "ash2");
        check("ash2 shr", int'(shr_o[1]), 14);
        step(1'b1, 4'b0000, "ash3");
        check("ash3 shr", int'(shr_o[1]), 15);

        // 5. Rotate from 0001 returns after W shifts
        step(1'b0, 4'b0001, "ld0001");
        for (int k = 0; k < W; k++) step(1'b1, $urandom_range(0, 15), "rot");
        check("rot return", int'(shr_o[2]), 1);

        // 6. Async reset mid-shift, then reload
        step(1'b0, 4'b1111, "ld1111");
        step(1'b1, 4'b0000, "pre_rst");
        check("pre_rst shr", int'(shr_o[0]), 7);
        async_reset_pulse("midshift");
        step(1'b0, 4'b1111, "post_rst");
        check("post_rst shr", int'(shr_o[0]), 15);

        // Randomized traffic with occasional async resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset_pulse("rand");
            end else begin
                step(($urandom_range(0, 2) != 0), $urandom_range(0, 15), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg.md
Name: shift_reg

Overview:
- Parameterizable parallel-load, right-shift register; default 4 bits.
- While `en` is low, the register tracks the parallel `load` value every clock.
- While `en` is high, the register shifts right one position per clock.
- Used as a simple serializer/shifter; status outputs (`sout`, `zero`) support a downstream consumer.

Parameters:
- WIDTH, 4, register width in bits (legal: >= 2).
- FILL_MODE, 0, fill for vacated MSB on shift: 0 = logical (fill 0), 1 = arithmetic (replicate old MSB), 2 = rotate (old LSB enters MSB).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  shift enable; 1 = shift right, 0 = parallel load.
- load  input  WIDTH  parallel load value.
- shr  output  WIDTH  current register contents.
- sout  output  1  bit shifted out on the most recent shift (registered).
- zero  output  1  combinational; 1 when shr == 0.

Behaviour:
- Reset:
  - rst low forces shr = 0 and sout = 0 immediately, with no clock needed; zero therefore reads 1.
  - Contents are held at 0 while rst is low.
  - Release is synchronous to the next rising edge: the first update occurs on the first rising clk edge with rst high.
- Each rising clk edge with rst high:
  - en = 0: shr <= load; sout is unchanged.
  - en = 1: shr <= {fill, shr[WIDTH-1:1]}; sout <= shr[0].
- Fill bit by FILL_MODE:
  - FILL_MODE 0: fill = 0.
  - FILL_MODE 1: fill = shr[WIDTH-1].
  - FILL_MODE 2: fill = shr[0].
- Latency:
  - Load is visible on shr one edge after being sampled.
  - Each enabled edge produces exactly one shift; there is no multi-bit shift.
- Logical mode: after WIDTH consecutive shifts, shr = 0 and stays 0 on further shifts; sout = 0 thereafter.
- Rotate mode: after WIDTH shifts, shr returns to its starting value.
- en toggling is sampled only at the edge; glitches between edges have no effect.
- rst asserted mid-shift sequence: immediate clear, and the pending sequence is abandoned. After release, the first edge with en = 0 reloads load.
- load changes while en = 1 are ignored.
- No X propagation: all state bits are reset.

Test Plan:
1. Reset/load: rst = 0 with load = 0111 -> shr = 0000, zero = 1. Release rst, en = 0, one edge -> shr = 0111, zero = 0.
2. Logical shift (FILL_MODE 0): from 0111, en = 1 for 4 edges -> shr = 0011, 0001, 0000, 0000; sout = 1, 1, 1, 0. Zero asserts after edge 3.
3. Shift then hold-load: from 0111 shift one edge (0011), drop en, change load to 1010 -> next edge shr = 1010, and sout holds 1.
4. Arithmetic mode (FILL_MODE 1): load 1000, shift 3 edges -> 1100, 1110, 1111.
5. Rotate mode (FILL_MODE 2): load 0001, shift 4 edges -> 1000, 0100, 0010, 0001.
6. Async reset mid-shift: load 1111, shift 1 edge (0111), pull rst low between edges -> shr = 0000 and sout = 0 without a clock edge. Release with en = 0 -> next edge reloads load.
